// File: rtl/seg_grade_decoder.sv
// ---------------------------------------------------------------------------
// seg_grade_decoder
//
// Receive-side checker for the grade/status seven-segment encoder. Watches
// the segment bus, waits for a pattern to stay stable, then decodes it back
// to a grade digit (0..10) or a status letter (P/F/A). Each newly stable
// pattern produces one pulse (valid or err). Accepted status letters are
// counted in saturating tallies.
//
// Optional build macro: SEG_DP_STRICT_EN
//   When defined, the decimal point (bit7) takes part in change detection,
//   any accepted pattern with bit7=1 is reported as unrecognised, and only
//   8'h00 counts as blank. When undefined, bit7 is ignored entirely.
//
// Parameters:
//   STABLE_CYCLES  consecutive equal samples needed for acceptance (>=1)
//   CNT_BITS       width of each status tally
//
// Ports:
//   clk_2        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   seg_in       in   [7:0] segment bus: bit7 = DP, bits6..0 = g f e d c b a
//   mode_status  in   0 = grade digit, 1 = status letter
//   valid        out  one-cycle pulse: recognised pattern accepted
//   err          out  one-cycle pulse: unrecognised non-blank pattern accepted
//   nota_out     out  [3:0] last decoded grade
//   kind         out  [1:0] 0 digit, 1 P (fail), 2 F (final), 3 A (pass)
//   cnt_fail     out  [CNT_BITS-1:0] tally of accepted P
//   cnt_final    out  [CNT_BITS-1:0] tally of accepted F
//   cnt_pass     out  [CNT_BITS-1:0] tally of accepted A
// ---------------------------------------------------------------------------
module seg_grade_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_BITS      = 8
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [7:0]          seg_in,
  input  logic                mode_status,
  output logic                valid,
  output logic                err,
  output logic [3:0]          nota_out,
  output logic [1:0]          kind,
  output logic [CNT_BITS-1:0] cnt_fail,
  output logic [CNT_BITS-1:0] cnt_final,
  output logic [CNT_BITS-1:0] cnt_pass
);

  localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

`ifdef SEG_DP_STRICT_EN
  localparam int CMP_W = 8;
`else
  localparam int CMP_W = 7;
`endif

  logic [CMP_W-1:0] cand_reg;
  logic             mode_reg;
  logic [SCW-1:0]   stab_cnt_reg;
  logic [1:0]       state_reg;

  logic             change;
  logic             dec_hit;
  logic [3:0]       dec_nota;
  logic [1:0]       dec_kind;
  logic             pat_blank;
  logic             dp_bad;
  logic             accept_now;
  logic             accept_ok;
  logic             accept_bad;

  assign change = (seg_in[CMP_W-1:0] != cand_reg) || (mode_status != mode_reg);

`ifdef SEG_DP_STRICT_EN
  assign pat_blank = (cand_reg == 8'h00);
  assign dp_bad    = cand_reg[7];
`else
  // DP bit is deliberately dropped in this build.
  logic unused_dp;
  assign unused_dp = seg_in[7];
  assign pat_blank = (cand_reg == 7'd0);
  assign dp_bad    = 1'b0;
`endif

  // Decode of the held candidate under the mode it was captured with.
  always_comb begin
    dec_hit  = 1'b0;
    dec_nota = 4'd0;
    dec_kind = 2'd0;
    if (!mode_reg) begin
      dec_hit = 1'b1;
      case (cand_reg[6:0])
        7'b0111111: dec_nota = 4'd0;
        7'b0000110: dec_nota = 4'd1;  // also the encoder's "I"; reads as 1
        7'b1011011: dec_nota = 4'd2;
        7'b1001111: dec_nota = 4'd3;
        7'b1100110: dec_nota = 4'd4;
        7'b1101101: dec_nota = 4'd5;
        7'b1111101: dec_nota = 4'd6;
        7'b0000111: dec_nota = 4'd7;
        7'b1111111: dec_nota = 4'd8;
        7'b1101111: dec_nota = 4'd9;
        7'b1011110: dec_nota = 4'd10;
        default:    dec_hit  = 1'b0;
      endcase
    end else begin
      dec_hit = 1'b1;
      case (cand_reg[6:0])
        7'b1110011: dec_kind = 2'd1;  // P
        7'b1110001: dec_kind = 2'd2;  // F
        7'b1110111: dec_kind = 2'd3;  // A
        default:    dec_hit  = 1'b0;
      endcase
    end
  end

  // Acceptance happens on the edge where the counter already sits at its
  // final value and the input still matches the candidate.
  assign accept_now = (state_reg == ST_WAIT) && !change && (stab_cnt_reg == STAB_LAST);
  assign accept_ok  = accept_now && !pat_blank && dec_hit && !dp_bad;
  assign accept_bad = accept_now && !pat_blank && !(dec_hit && !dp_bad);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      cand_reg     <= '0;
      mode_reg     <= 1'b0;
      stab_cnt_reg <= '0;
      state_reg    <= ST_IDLE;
      valid        <= 1'b0;
      err          <= 1'b0;
      nota_out     <= 4'd0;
      kind         <= 2'd0;
    end else begin
      valid <= accept_ok;
      err   <= accept_bad;
      if (change) begin
        cand_reg     <= seg_in[CMP_W-1:0];
        mode_reg     <= mode_status;
        stab_cnt_reg <= '0;
        state_reg    <= ST_WAIT;
      end else if (state_reg == ST_WAIT) begin
        if (stab_cnt_reg == STAB_LAST) begin
          state_reg <= ST_HELD;
        end else begin
          stab_cnt_reg <= stab_cnt_reg + SCW'(1);
        end
      end
      if (accept_ok) begin
        if (!mode_reg) begin
          nota_out <= dec_nota;
          kind     <= 2'd0;
        end else begin
          kind <= dec_kind;
        end
      end
    end
  end

  // One saturating tally per status letter; index gi maps to kind gi+1.
  logic [CNT_BITS-1:0] tally_reg [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tally
      always_ff @(posedge clk_2) begin
        if (reset) begin
          tally_reg[gi] <= '0;
        end else if (accept_ok && mode_reg && (dec_kind == 2'(gi + 1)) &&
                     (tally_reg[gi] != {CNT_BITS{1'b1}})) begin
          tally_reg[gi] <= tally_reg[gi] + CNT_BITS'(1);
        end
      end
    end
  endgenerate

  assign cnt_fail  = tally_reg[0];
  assign cnt_final = tally_reg[1];
  assign cnt_pass  = tally_reg[2];

endmodule
